uart_rx_frame: RTL and testbench



---
 rtl/uart_rx_frame.sv | 124 ++++++++++++
 tb/tb_uart_rx_frame.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receiver: oversampled start/data/parity/stop recovery with a one-clock
// result strobe and per-frame parity and framing error flags.
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_baud_tick,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_busy,
  output logic [2:0]            o_dbg_state
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic             ODD_BIT  = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_next;
  logic                  rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err;
  logic                  half_hit, full_hit, stop_done;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign half_hit  = i_baud_tick && (cnt == CNT_HALF);
  assign full_hit  = i_baud_tick && (cnt == CNT_FULL);
  assign stop_done = (state == STOP) && full_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      o_busy <= 1'b0;
    end else begin
      state  <= state_next;
      o_busy <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rx_prev && !rx_s) state_next = START;
      START:   if (half_hit) state_next = rx_s ? IDLE : DATA;
      DATA:    if (full_hit && bit_cnt == BIT_LAST)
                 state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (full_hit) state_next = STOP;
      STOP:    if (full_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Leaving START at mid-bit means every later sample lands one full bit later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
    end else begin
      if (state_next != state)
        cnt <= '0;
      else if (i_baud_tick)
        cnt <= (cnt == CNT_FULL) ? '0 : cnt + 1'b1;

      if (state != DATA)
        bit_cnt <= '0;
      else if (full_hit)
        bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && full_hit)
        shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};

      if (state == START)
        par_err <= 1'b0;
      else if (state == PARITY && full_hit)
        par_err <= ((^shreg ^ rx_s) != ODD_BIT);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= stop_done;
      if (stop_done) begin
        o_data       <= shreg;
        o_parity_err <= par_err;
        o_frame_err  <= ~rx_s;
      end
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: one even-parity instance and one no-parity instance,
// frames built from a word/parity/stop description and checked against a queue.
module tb_uart_rx_frame;

  localparam int OS       = 16;
  localparam int TICK_DIV = 3;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic       clk, rst_n, baud_tick;
  logic       rx_p, rx_n;
  logic [7:0] d_p, d_n;
  logic       v_p, pe_p, fe_p, busy_p;
  logic       v_n, pe_n, fe_n, busy_n;
  logic [2:0] dbg_p, dbg_n;

  int chk_cnt = 0;
  int err_cnt = 0;
  int div     = 0;

  // Entries are {frame_err, parity_err, data}.
  logic [9:0] exp_q[$];
  logic [9:0] exp_n[$];
  logic [9:0] got_p[$];
  logic [9:0] got_n[$];

  uart_rx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick(baud_tick), .i_rx(rx_p),
    .o_data(d_p), .o_valid(v_p), .o_parity_err(pe_p), .o_frame_err(fe_p),
    .o_busy(busy_p), .o_dbg_state(dbg_p)
  );

  uart_rx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick(baud_tick), .i_rx(rx_n),
    .o_data(d_n), .o_valid(v_n), .o_parity_err(pe_n), .o_frame_err(fe_n),
    .o_busy(busy_n), .o_dbg_state(dbg_n)
  );

  // clock / baud strobe
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % TICK_DIV;
      baud_tick = (div == 0);
    end
  end

  // result collector
  always @(negedge clk) begin
    if (v_p) got_p.push_back({fe_p, pe_p, d_p});
    if (v_n) got_n.push_back({fe_n, pe_n, d_n});
  end

  // reference model: even parity error when total ones (data + parity bit) is odd
  function automatic logic [9:0] model_p(input logic [7:0] d, input logic par, input logic stp);
    int ones;
    ones = $countones(d) + int'(par);
    return {~stp, (ones % 2) != 0, d};
  endfunction

  // drivers
  task automatic bit_time();
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_p(input logic [7:0] d, input logic par, input logic stp);
    rx_p = 1'b0; bit_time();
    for (int i = 0; i < 8; i++) begin rx_p = d[i]; bit_time(); end
    rx_p = par; bit_time();
    rx_p = stp; bit_time();
  endtask

  task automatic send_n(input logic [7:0] d, input logic stp);
    rx_n = 1'b0; bit_time();
    for (int i = 0; i < 8; i++) begin rx_n = d[i]; bit_time(); end
    rx_n = stp; bit_time();
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; rx_p = 1'b1; rx_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk_cnt++;
    if ({d_p, v_p, pe_p, fe_p, busy_p} !== 12'h0) begin
      err_cnt++; $display("FAIL reset_p got=%h exp=000", {d_p, v_p, pe_p, fe_p, busy_p});
    end
    chk_cnt++;
    if ({d_n, v_n, pe_n, fe_n, busy_n} !== 12'h0) begin
      err_cnt++; $display("FAIL reset_n got=%h exp=000", {d_n, v_n, pe_n, fe_n, busy_n});
    end
    @(negedge clk); rst_n = 1'b1;
    bit_time();
  endtask

  task automatic test_good_frame();
    logic [9:0] e, g;
    exp_q.push_back(model_p(8'hA5, 1'b0, 1'b1));
    send_p(8'hA5, 1'b0, 1'b1);
    rx_p = 1'b1; bit_time();
    chk_cnt++;
    if (got_p.size() != 1) begin
      err_cnt++; $display("FAIL good_count got=%0d exp=1", got_p.size());
    end
    if (got_p.size() > 0) begin
      e = exp_q.pop_front(); g = got_p.pop_front(); chk_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL good_word got=%h exp=%h", g, e); end
    end
    chk_cnt++;
    if (busy_p !== 1'b0) begin err_cnt++; $display("FAIL good_busy got=%b exp=0", busy_p); end
    exp_q.delete(); got_p.delete();
  endtask

  task automatic test_parity_err();
    logic [9:0] g;
    send_p(8'h3C, 1'b1, 1'b1);
    rx_p = 1'b1; bit_time();
    chk_cnt++;
    if (got_p.size() != 1) begin
      err_cnt++; $display("FAIL par_count got=%0d exp=1", got_p.size());
    end
    if (got_p.size() > 0) begin
      g = got_p.pop_front(); chk_cnt++;
      if (g !== {1'b0, 1'b1, 8'h3C}) begin err_cnt++; $display("FAIL par_word got=%h exp=13c", g); end
    end
    got_p.delete();
  endtask

  task automatic test_break();
    logic [9:0] g;
    send_p(8'h81, 1'b0, 1'b0);
    repeat (33) bit_time();
    chk_cnt++;
    if (got_p.size() != 1) begin
      err_cnt++; $display("FAIL brk_count got=%0d exp=1", got_p.size());
    end
    if (got_p.size() > 0) begin
      g = got_p.pop_front(); chk_cnt++;
      if (g !== {1'b1, 1'b0, 8'h81}) begin err_cnt++; $display("FAIL brk_word got=%h exp=281", g); end
    end
    got_p.delete();
    rx_p = 1'b1; bit_time(); bit_time();
    send_p(8'h55, 1'b0, 1'b1);
    rx_p = 1'b1; bit_time();
    chk_cnt++;
    if (got_p.size() != 1) begin
      err_cnt++; $display("FAIL brk_recover_count got=%0d exp=1", got_p.size());
    end
    if (got_p.size() > 0) begin
      g = got_p.pop_front(); chk_cnt++;
      if (g !== {1'b0, 1'b0, 8'h55}) begin err_cnt++; $display("FAIL brk_recover_word got=%h exp=055", g); end
    end
    got_p.delete();
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    rx_p = 1'b0;
    repeat ((OS / 4) * TICK_DIV) begin @(negedge clk); seen |= busy_p; end
    rx_p = 1'b1;
    repeat (BIT_CLKS) begin @(negedge clk); seen |= busy_p; end
    chk_cnt++;
    if (seen !== 1'b1) begin err_cnt++; $display("FAIL glitch_busy_seen got=%b exp=1", seen); end
    chk_cnt++;
    if (busy_p !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy_end got=%b exp=0", busy_p); end
    chk_cnt++;
    if (got_p.size() != 0) begin err_cnt++; $display("FAIL glitch_valid got=%0d exp=0", got_p.size()); end
    got_p.delete();
  endtask

  task automatic test_back_to_back();
    logic [9:0] e, g;
    exp_n.push_back({2'b00, 8'h00});
    exp_n.push_back({2'b00, 8'hFF});
    send_n(8'h00, 1'b1);
    send_n(8'hFF, 1'b1);
    rx_n = 1'b1; bit_time();
    chk_cnt++;
    if (got_n.size() != 2) begin err_cnt++; $display("FAIL b2b_count got=%0d exp=2", got_n.size()); end
    while (got_n.size() > 0 && exp_n.size() > 0) begin
      e = exp_n.pop_front(); g = got_n.pop_front(); chk_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL b2b_word got=%h exp=%h", g, e); end
    end
    exp_n.delete(); got_n.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic [9:0] g;
    d = 8'hC3;
    rx_p = 1'b0; bit_time();
    for (int i = 0; i < 4; i++) begin rx_p = d[i]; bit_time(); end
    rx_p = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0; rx_p = 1'b1;
    #1;
    chk_cnt++;
    if ({d_p, v_p, pe_p, fe_p, busy_p} !== 12'h0) begin
      err_cnt++; $display("FAIL rst_mid got=%h exp=000", {d_p, v_p, pe_p, fe_p, busy_p});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bit_time();
    got_p.delete();
    send_p(8'h5A, 1'b0, 1'b1);
    rx_p = 1'b1; bit_time();
    chk_cnt++;
    if (got_p.size() != 1) begin err_cnt++; $display("FAIL rst_next_count got=%0d exp=1", got_p.size()); end
    if (got_p.size() > 0) begin
      g = got_p.pop_front(); chk_cnt++;
      if (g !== {2'b00, 8'h5A}) begin err_cnt++; $display("FAIL rst_next_word got=%h exp=05a", g); end
    end
    got_p.delete();
  endtask

  task automatic test_random_parity();
    logic [7:0] d;
    logic       par, stp;
    logic [9:0] e, g;
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom_range(0, 255));
      par = 1'($countones(d) % 2);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp = ($urandom_range(0, 4) != 0);
      exp_q.push_back(model_p(d, par, stp));
      send_p(d, par, stp);
      rx_p = 1'b1;
      if (!stp) bit_time();
      repeat ($urandom_range(0, 2)) bit_time();
    end
    bit_time();
    chk_cnt++;
    if (got_p.size() != exp_q.size()) begin
      err_cnt++; $display("FAIL rnd_p_count got=%0d exp=%0d", got_p.size(), exp_q.size());
    end
    while (got_p.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_p.pop_front(); chk_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL rnd_p_word got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_p.delete();
  endtask

  task automatic test_random_noparity();
    logic [7:0] d;
    logic       stp;
    logic [9:0] e, g;
    for (int n = 0; n < 8; n++) begin
      d   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 4) != 0);
      exp_n.push_back({~stp, 1'b0, d});
      send_n(d, stp);
      rx_n = 1'b1;
      if (!stp) bit_time();
      repeat ($urandom_range(0, 2)) bit_time();
    end
    bit_time();
    chk_cnt++;
    if (got_n.size() != exp_n.size()) begin
      err_cnt++; $display("FAIL rnd_n_count got=%0d exp=%0d", got_n.size(), exp_n.size());
    end
    while (got_n.size() > 0 && exp_n.size() > 0) begin
      e = exp_n.pop_front(); g = got_n.pop_front(); chk_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL rnd_n_word got=%h exp=%h", g, e); end
    end
    exp_n.delete(); got_n.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_parity();
    test_random_noparity();
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
